// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter in front of a single-port memory with a
//            fixed read latency. FSM: IDLE -> ACCESS -> (WAIT) -> RESP.
// Config   : MEM_ARB_RR_EN defined   -> round-robin on simultaneous requests
//            MEM_ARB_RR_EN undefined -> fixed priority, requester 0 wins
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // WAIT counter is loaded with RD_LAT-1 and counts down to zero,
  // so two bits cover the whole 1..4 latency range.
  localparam logic [1:0] c_WAIT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_winner;   // 0 = requester 0, 1 = requester 1
  logic [1:0]        r_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
`ifdef MEM_ARB_RR_EN
  logic              r_last;     // requester granted most recently
`endif

  logic              w_any_req;
  logic              w_grant;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Pick the winner among the requests currently presented.
  always_comb begin
    w_any_req = req0 | req1;
`ifdef MEM_ARB_RR_EN
    // On contention the requester not granted last wins.
    if (req0 && req1) begin
      w_grant = ~r_last;
    end else begin
      w_grant = req1;
    end
`else
    // Requester 0 always wins when it is asking.
    w_grant = ~req0;
`endif
    w_sel_wr    = w_grant ? wr1    : wr0;
    w_sel_addr  = w_grant ? addr1  : addr0;
    w_sel_wdata = w_grant ? wdata1 : wdata0;
  end

  // Transaction FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_winner    <= 1'b0;
      r_cnt       <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
`ifdef MEM_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      // Pulses default low; only the transition that needs them raises them.
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            // The memory command registers double as the latched request,
            // so they naturally hold their values outside ACCESS.
            r_winner    <= w_grant;
            r_mem_wr    <= w_sel_wr;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
`ifdef MEM_ARB_RR_EN
            r_last      <= w_grant;
`endif
          end
        end
        ST_ACCESS: begin
          if (r_mem_wr) begin
            r_ack0  <= ~r_winner;
            r_ack1  <= r_winner;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= c_WAIT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= mem_rdata;
            r_ack0  <= ~r_winner;
            r_ack1  <= r_winner;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: vector table of single
//            transactions, contention, reset-in-WAIT and late-request
//            sequences, with a scoreboard of expected acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, busy, mem_en, mem_wr;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit              p;
    bit              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] rd;
  } item_t;

  item_t sb[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten locations return a fixed address pattern
  // (location 3F reads A7); read data is valid RD_LAT cycles after mem_en.
  logic [DATA_W-1:0] mem [64];
  logic [63:0]       vld = '0;
  logic [DATA_W-1:0] pipe [RD_LAT];

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    return vld[a] ? mem[a] : ({2'b10, a} ^ 8'h18);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      vld[mem_addr] <= 1'b1;
    end
    pipe[0] <= rd_val(mem_addr);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: memory command and ack checked against the head item.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        if (sb.size() == 0) chk("unexpected_mem_en", 1, 0);
        else begin
          chk("mem_wr", mem_wr, sb[0].w);
          chk("mem_addr", mem_addr, sb[0].a);
          if (sb[0].w) chk("mem_wdata", mem_wdata, sb[0].d);
        end
      end
      if (ack0 || ack1) begin
        chk("ack_onehot", ack0 & ack1, 0);
        if (sb.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          item_t it;
          it = sb.pop_front();
          chk("ack_port", ack1, it.p);
          chk("rdata", rdata, it.rd);
        end
      end
    end
  end

  task automatic drive(input bit p, input bit r, input bit w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p) begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
  endtask

  // One isolated transaction; cycle 1 is the cycle after the sampling edge.
  task automatic txn(input bit p, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
    int  cyc;
    bit  seen;
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    sb.push_back('{p: p, w: w, a: a, d: d, rd: exp_rd});
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("busy_c1", busy, 1);
        chk("mem_en_c1", mem_en, 1);
      end
      seen = p ? ack1 : ack0;
    end
    drive(p, 1'b0, w, a, d);
    chk("ack_latency", cyc, w ? 2 : 2 + RD_LAT);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("mem_en_idle", mem_en, 0);
    chk("mem_addr_hold", mem_addr, a);
  endtask

  typedef struct {
    bit                p;
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_exp, got, cyc, ack0_c, en1_c, ack1_c;
    int ack_c[4];

    // vector table: expected rdata for a write is the unchanged previous read
    tbl[0] = '{p: 0, w: 1, a: 6'h2A, d: 8'h5C, exp_rd: 8'h00};
    tbl[1] = '{p: 1, w: 0, a: 6'h3F, d: 8'h00, exp_rd: 8'hA7};
    tbl[2] = '{p: 1, w: 1, a: 6'h10, d: 8'h33, exp_rd: 8'hA7};
    tbl[3] = '{p: 0, w: 0, a: 6'h10, d: 8'h00, exp_rd: 8'h33};
    tbl[4] = '{p: 0, w: 0, a: 6'h2A, d: 8'h00, exp_rd: 8'h5C};
    tbl[5] = '{p: 1, w: 1, a: 6'h2A, d: 8'h99, exp_rd: 8'h5C};
    tbl[6] = '{p: 1, w: 0, a: 6'h2A, d: 8'h00, exp_rd: 8'h99};

    rst_n = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) txn(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd);

    // contention: both held high; the last grant above was requester 1
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 6'h05, 8'h11);
    drive(1, 1'b1, 1'b1, 6'h06, 8'h22);
`ifdef MEM_ARB_RR_EN
    n_exp = 4;
    for (int i = 0; i < 4; i++)
      if (i % 2 == 0) sb.push_back('{p: 0, w: 1, a: 6'h05, d: 8'h11, rd: 8'h99});
      else            sb.push_back('{p: 1, w: 1, a: 6'h06, d: 8'h22, rd: 8'h99});
`else
    n_exp = 3;
    for (int i = 0; i < 3; i++)
      sb.push_back('{p: 0, w: 1, a: 6'h05, d: 8'h11, rd: 8'h99});
`endif
    got = 0;
    cyc = 0;
    while (got < n_exp && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        ack_c[got] = cyc;
        got++;
        if (got == n_exp) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("contention_acks", got, n_exp);
    chk("contention_first", ack_c[0], 2);
    for (int i = 1; i < n_exp && i < got; i++)
      chk("write_throughput", ack_c[i] - ack_c[i-1], 3);
    repeat (3) @(negedge clk);
    chk("contention_idle", busy, 0);
    sb.delete();

    // reset pulse during WAIT of a read
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 6'h2A, 8'h00);
    sb.push_back('{p: 0, w: 0, a: 6'h2A, d: 8'h00, rd: 8'h99});
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_ack", {ack0, ack1}, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wr", mem_wr, 0);
    sb.delete();
    drive(0, 1'b0, 1'b0, 6'h2A, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
    end
    txn(0, 1'b0, 6'h2A, 8'h00, 8'h99);

    // late request: req1 raised while req0 is in ACCESS
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 6'h07, 8'h44);
    sb.push_back('{p: 0, w: 1, a: 6'h07, d: 8'h44, rd: 8'h99});
    cyc = 0; ack0_c = 0; en1_c = 0; ack1_c = 0;
    while (ack1_c == 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        drive(1, 1'b1, 1'b0, 6'h3F, 8'h00);
        sb.push_back('{p: 1, w: 0, a: 6'h3F, d: 8'h00, rd: 8'hA7});
      end
      if (ack0) begin
        ack0_c = cyc;
        req0 = 1'b0;
      end
      if (mem_en && cyc > 1) en1_c = cyc;
      if (ack1) begin
        ack1_c = cyc;
        req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("late_ack0_cyc", ack0_c, 2);
    chk("late_en1_cyc", en1_c, 4);
    chk("late_ack1_cyc", ack1_c, 5 + RD_LAT);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning the memory address width in bits (64 locations).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the data width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1-4, meaning the memory read latency in cycles after mem_en.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req0 and req1, input, 1 bit each: requester access request, held until ack.
REQ-007 SHALL have ports wr0 and wr1, input, 1 bit each: 1 = write, 0 = read; valid while req is high.
REQ-008 SHALL have ports addr0 and addr1, input, ADDR_W bits each: requester address.
REQ-009 SHALL have ports wdata0 and wdata1, input, DATA_W bits each: requester write data.
REQ-010 SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, DATA_W bits: read result, valid when ack0 or ack1 is high after a read.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have ports mem_en and mem_wr, output, 1 bit each; mem_addr, output, ADDR_W bits; mem_wdata, output, DATA_W bits: the memory command.
REQ-014 SHALL have port mem_rdata, input, DATA_W bits: valid RD_LAT cycles after the mem_en cycle.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACCESS, WAIT and RESP.
REQ-016 IDLE: when any req is sampled high at a clock edge, SHALL pick a winner, latch its wr, addr and wdata, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 ACCESS: SHALL last exactly 1 cycle with mem_en=1 and mem_wr, mem_addr and mem_wdata taken from the latched values; it SHALL then go to WAIT for a read or to RESP for a write.
REQ-018 WAIT: SHALL last exactly RD_LAT cycles using a counter; on the edge that ends the last WAIT cycle, SHALL capture mem_rdata into rdata and go to RESP.
REQ-019 RESP: SHALL last 1 cycle, with the winner's ack=1 and the other ack=0, then go to IDLE.
REQ-020 Latency with req rising before edge 0: mem_en in cycle 1; write ack in cycle 2; read ack in cycle 2+RD_LAT.
REQ-021 mem_en SHALL be 0 outside ACCESS.
REQ-022 mem_wr, mem_addr and mem_wdata SHALL hold their last values outside ACCESS.
REQ-023 A write SHALL leave rdata unchanged.
REQ-024 rdata SHALL hold its value until the next read capture.
REQ-025 A req that falls before its ack SHALL NOT abort the transaction; it completes and acks normally.
REQ-026 A requester SHALL drop req on the edge where it samples ack; a req still high in IDLE after RESP SHALL be treated as a new request.
REQ-027 Simultaneous req0 and req1 in IDLE: SHALL grant the requester not granted last (round-robin pointer, see REQ-032).
REQ-028 A request arriving while busy SHALL wait without being lost; it is arbitrated on the next IDLE cycle.
REQ-029 Back-to-back throughput SHALL be at most one transaction per (3 + RD_LAT) cycles for reads and one per 3 cycles for writes, the IDLE cycle included.

Reset
REQ-030 rst_n low SHALL immediately force: FSM=IDLE; mem_en, mem_wr, ack0, ack1 and busy = 0; mem_addr, mem_wdata and rdata = 0; round-robin pointer = "last granted 1", so req0 wins first.
REQ-031 Reset during ACCESS, WAIT or RESP SHALL drop the transaction without issuing an ack; after release the FSM starts in IDLE.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: SHALL arbitrate round-robin as in REQ-027, updating the pointer on each grant.
REQ-033 Macro MEM_ARB_RR_EN undefined: SHALL use fixed priority (req0 always wins simultaneous requests) and SHALL contain no pointer register.

Verification
REQ-034 Write test: req0=1, wr0=1, addr0=6'h2A, wdata0=8'h5C at edge 0 -> cycle 1 shows mem_en=1, mem_wr=1, mem_addr=2A, mem_wdata=5C; cycle 2 shows ack0=1; rdata unchanged.
REQ-035 Read test (RD_LAT=1): req1 read of addr 6'h3F with the memory model returning 8'hA7 -> mem_en in cycle 1; ack1=1 in cycle 3 with rdata=A7.
REQ-036 Contention test: req0 and req1 both held high continuously, MEM_ARB_RR_EN defined -> grants follow 0,1,0,1; undefined -> grants follow 0,0,0.
REQ-037 Reset test: rst_n pulsed low during the WAIT state of a read -> all outputs 0 immediately, no ack issued, busy=0; the next request completes normally.
REQ-038 Late request test: req1 raised while req0 is in ACCESS -> req1 is granted in the IDLE cycle after ack0, and mem_en for req1 follows one cycle later.
